// File: rtl/led_sequencer.sv
// LED pattern generator: prescaled or manually stepped phase counter decoded into binary/rotate/bounce/fill patterns.
// Latency: 1 edge from advance to leds/flag/tick; no backpressure, every advance is taken immediately.
module led_sequencer #(
    parameter int CLK_HZ  = 12000000,
    parameter int TICK_HZ = 1,
    parameter int NLEDS   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             step,
    input  logic [1:0]       mode,
    output logic [NLEDS-1:0] leds,
    output logic             flag,
    output logic             tick
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW  = (NLEDS > $clog2(2*NLEDS) + 1) ? NLEDS : $clog2(2*NLEDS) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {
        MODE_BINARY = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_t;

    logic [DW-1:0] div;
    logic [PW-1:0] phase;
    mode_t         mode_q;

    logic             advance;
    mode_t            nxt_mode;
    int               nxt_ph;
    logic [NLEDS-1:0] nxt_leds;
    logic             nxt_flag;

    function automatic int period(input mode_t m);
        case (m)
            MODE_BINARY: return 1 << NLEDS;
            MODE_ROTATE: return NLEDS;
            MODE_BOUNCE: return 2*NLEDS - 2;
            default:     return 2*NLEDS;
        endcase
    endfunction

    function automatic logic [NLEDS-1:0] decode(input mode_t m, input int p);
        logic [NLEDS-1:0] one;
        int               pos;
        one = NLEDS'(1);
        case (m)
            MODE_BINARY: return NLEDS'(p);
            MODE_ROTATE: return one << p;
            MODE_BOUNCE: begin
                pos = (p < NLEDS) ? p : 2*NLEDS - 2 - p;
                return one << pos;
            end
            default: begin
                pos = (p <= NLEDS) ? p : 2*NLEDS - p;
                return NLEDS'((1 << pos) - 1);
            end
        endcase
    endfunction

    // While en is low the divider is frozen, so a pending count survives a manual-step session.
    assign advance = en ? (div == DIV_LAST) : step;

    always_comb begin
        nxt_mode = mode_q;
        nxt_ph   = 0;
        if (mode_t'(mode) != mode_q) begin
            nxt_mode = mode_t'(mode);
            nxt_ph   = 0;
        end else if (int'(phase) != period(mode_q) - 1) begin
            nxt_ph = int'(phase) + 1;
        end
        nxt_leds = decode(nxt_mode, nxt_ph);
        nxt_flag = (nxt_ph < period(nxt_mode) / 2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div    <= '0;
            phase  <= '0;
            mode_q <= MODE_BINARY;
            leds   <= '0;
            flag   <= 1'b1;
            tick   <= 1'b0;
        end else begin
            if (en) begin
                div <= (div == DIV_LAST) ? '0 : div + DW'(1);
            end
            tick <= advance;
            if (advance) begin
                mode_q <= nxt_mode;
                phase  <= PW'(nxt_ph);
                leds   <= nxt_leds;
                flag   <= nxt_flag;
            end
        end
    end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised LED pattern generator for the board-level demo tops. A prescaler turns the board clock into a slow step tick. On each tick a phase counter advances through one of four selectable patterns (binary count, rotate, bounce, fill/empty), driving NLEDS outputs plus a half-period flag. It also supports a manual single-step mode and a glitch-free mode change, so demo tops can use it instead of ad-hoc divider/counter logic.

## Interface
- CLK_HZ, 12000000, input clock frequency in Hz
- TICK_HZ, 1, pattern step rate in Hz; DIV = CLK_HZ/TICK_HZ, DIV >= 2 required
- NLEDS, 4, number of LED outputs, 2..16
- clk  input  1  board clock; all state on its rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  1 = free-run on prescaler ticks; 0 = prescaler frozen, manual stepping
- step  input  1  manual advance request, honoured only while en = 0, one step per cycle held high
- mode  input  2  0 binary, 1 rotate, 2 bounce, 3 fill/empty; sampled only on an advance
- leds  output  NLEDS  registered pattern
- flag  output  1  registered; 1 while phase is in first half of current mode's period
- tick  output  1  registered one-cycle pulse on each cycle in which leds/flag took a new value

## Operation
- Prescaler: counter width $clog2(DIV), counts 0..DIV-1 while en = 1, wraps to 0. Raw advance = (en & div == DIV-1) | (~en & step). While en = 0 the divider holds its value and is not cleared.
- Registered state: mode_q (2 b), phase (width max(NLEDS, $clog2(2*NLEDS)+1)).
- Period P by mode_q: binary 2^NLEDS; rotate NLEDS; bounce 2*NLEDS-2; fill 2*NLEDS.
- On advance:
  - if mode != mode_q: mode_q <= mode, phase <= 0 (new mode starts at its first pattern, not advanced)
  - else phase <= (phase == P-1) ? 0 : phase+1
- Pattern decode from new (mode_q, phase), registered into leds:
  - binary: leds = phase[NLEDS-1:0]
  - rotate: leds = 1 << phase
  - bounce: pos = phase < NLEDS ? phase : 2*NLEDS-2-phase; leds = 1 << pos
  - fill: n = phase <= NLEDS ? phase : 2*NLEDS-phase; leds = low n bits set
- flag = (new phase < P/2), registered with leds.
- tick = 1 for exactly the cycle after each advance edge, else 0.
- No advance: leds, flag, phase and mode_q hold; a mode change without an advance has no visible effect.

## Timing
- Reset (async assert, any time): divider = 0, phase = 0, mode_q = 0, leds = 0, flag = 1, tick = 0, all immediately without a clock edge. Deassertion takes effect at the next rising edge.
- Free run: the first advance edge is the DIV-th rising edge after reset release with en = 1. Advances then repeat every DIV cycles.
- Manual: step high in cycle k -> leds/flag updated at edge ending k, tick high in cycle k+1. Step held N cycles -> N advances.
- en 1->0 mid-count: divider freezes; en 0->1 resumes from the frozen count.
- en = 1 and step = 1 in the same cycle: step ignored, only the divider advances.
- Mode change on the same edge as a phase wrap: the mode change wins; phase = 0 in the new mode.
- Latency from advance to output: 1 edge; no combinational path from any input to any output.

## Test plan
- NLEDS=4, CLK_HZ=8, TICK_HZ=1, en=1, mode=0 after reset -> leds steps 0,1,...,15,0 every 8 clocks; first change on clock 8; flag 1 for values 0..7, 0 for 8..15; tick pulse once per 8 clocks.
- en=0, mode=1, four step pulses -> first step loads 0001 (mode change, phase 0); next steps give 0010, 0100, 1000, then 0001; flag 1 only on 0001 and 0010.
- en=0, mode=2, steps -> 0001, 0010, 0100, 1000, 0100, 0010, 0001 (period 6); flag 1 on the first three.
- en=0, mode=3, steps -> 0000, 0001, 0011, 0111, 1111, 0111, 0011, 0001, 0000 (period 8); flag 1 on the first four.
- en=1 with step held high -> advance rate unchanged (every 8 clocks). en dropped at div=5 for 20 cycles and then raised -> next advance 3 clocks later.
- rst pulsed between clock edges mid-bounce -> leds=0, flag=1, tick=0 before the next edge; after release the first advance comes 8 clocks later in binary mode.
